// File: rtl/mmm_r2mm_iter.sv
// Iterative radix-2^D Montgomery multiplier: res = x*y*2^-K mod m.
// D chained radix-2 steps are applied per CALC cycle; K/D cycles per product.

module mmm_r2mm_step #(
  parameter int K = 64
) (
  input  logic [K:0]   s_in,
  input  logic         b,
  input  logic [K-1:0] y,
  input  logic [K-1:0] m,
  output logic [K:0]   s_out
);

  logic [K+1:0] a_y;
  logic [K+1:0] a_m;
  logic         unused_lsb;

  // Adding m when a_y is odd makes the sum even, so the shift is exact.
  always_comb begin
    a_y = {1'b0, s_in} + (b ? {2'b0, y} : '0);
    a_m = a_y[0] ? a_y + {2'b0, m} : a_y;
    {s_out, unused_lsb} = a_m;
  end

endmodule

module mmm_r2mm_iter #(
  parameter int K         = 64,
  parameter int D         = 1,
  parameter int FINAL_SUB = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic [K-1:0] m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K:0]   res
);

  localparam int ITERS = K / D;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  generate
    if ((D < 1) || (D > K) || ((K % D) != 0)) begin : g_bad_params
      $error("mmm_r2mm_iter: D must divide K and satisfy 1 <= D <= K");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;

  state_t          state, state_nxt;
  logic [K-1:0]    xr, yr, mr;
  logic [K:0]      s;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [D:0][K:0] chain;

  assign last      = (cnt == CW'(ITERS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One step per multiplier bit, LSB of the shifting x register first.
  assign chain[0] = s;
  generate
    for (genvar g = 0; g < D; g++) begin : g_step
      mmm_r2mm_step #(.K(K)) u_step (
        .s_in  (chain[g]),
        .b     (xr[g]),
        .y     (yr),
        .m     (mr),
        .s_out (chain[g+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (last)     state_nxt = (FINAL_SUB != 0) ? SUB : DONE;
      SUB:                state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xr  <= '0;
      yr  <= '0;
      mr  <= '0;
      s   <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr  <= x;
            yr  <= y;
            mr  <= m;
            s   <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          s   <= chain[D];
          xr  <= xr >> D;
          cnt <= cnt + 1'b1;
          if (last && (FINAL_SUB == 0)) res <= chain[D];
        end
        SUB: begin
          // S < 2m after CALC, so one conditional subtract fully reduces.
          if (s >= {1'b0, mr}) res <= s - {1'b0, mr};
          else                 res <= s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mmm_r2mm_iter.md
MMM_R2MM_ITER -- requirements
Module: mmm_r2mm_iter

Interface
REQ-001 SHALL have parameter K, default 64: operand/modulus width in bits.
REQ-002 SHALL have parameter D, default 1: multiplier bits consumed per CALC cycle.
REQ-003 SHALL have parameter FINAL_SUB, default 1: when 1, apply the final conditional subtraction; when 0, skip it.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: operands x, y, m valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept operands.
REQ-008 SHALL have port x, input, K: multiplier, consumed LSB first.
REQ-009 SHALL have port y, input, K: multiplicand.
REQ-010 SHALL have port m, input, K: odd modulus.
REQ-011 SHALL have port out_valid, output, 1: res valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts res.
REQ-013 SHALL have port res, output, K+1: x*y*2^-K mod m, or the unreduced value when FINAL_SUB=0.

Function
REQ-014 SHALL reject elaboration unless K%D==0, D>=1 and D<=K.
REQ-015 SHALL implement FSM states IDLE, CALC, SUB, DONE.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL, on in_valid&&in_ready, register x, y and m, clear accumulator S (K+1 bits) and iteration counter, and enter CALC.
REQ-018 SHALL, in each CALC cycle, apply D chained radix-2 steps to S, one per multiplier bit b, LSB first: a = S + b*y (K+2 bits); if a[0]==1 then a = a + m; S = a>>1.
REQ-019 SHALL shift the registered x right by D each CALC cycle and increment the counter; after K/D CALC cycles, go to SUB if FINAL_SUB=1, else to DONE with res=S.
REQ-020 SHALL, in SUB (one cycle), set res = S-m if S>=m, else res = S, then enter DONE.
REQ-021 SHALL hold out_valid=1 and res stable in DONE until out_ready==1, then return to IDLE on that edge.
REQ-022 SHALL, when FINAL_SUB=1, raise out_valid exactly K/D+1 cycles after the accepting edge; when FINAL_SUB=0, K/D cycles after.
REQ-023 SHALL ignore in_valid and all operand changes outside IDLE.
REQ-024 SHALL keep every intermediate sum at K+2 bits with no overflow, given m odd and x,y<m; S<2m SHALL hold at the end of CALC.
REQ-025 SHALL still run exactly K/D CALC cycles and terminate with inputs violating m odd or x,y<m; res value is then unspecified.
REQ-026 SHALL accept a new operation no earlier than the edge after the DONE handshake; no back-to-back overlap.

Reset
REQ-027 SHALL, while rst==1 at a clock edge, enter IDLE with in_ready=1, out_valid=0, res=0, S=0 and counter=0.
REQ-028 SHALL, when rst is asserted mid-CALC, mid-SUB or in DONE, abandon the operation with no out_valid pulse; rst SHALL take priority over every handshake.

Verification
REQ-029 SHALL cover K=8, D=1, m=13, x=5, y=7 -> res=1, with out_valid 9 cycles after accept.
REQ-030 SHALL cover K=8, D=2, m=13, x=12, y=12 -> res=3, with out_valid 5 cycles after accept.
REQ-031 SHALL cover K=8, m=13, x=0, y=9 -> res=0, and x=1, y=1 -> res=3 (2^-8 mod 13).
REQ-032 SHALL cover out_ready held low 10 cycles in DONE -> res and out_valid stable, in_ready=0, in_valid pulses ignored.
REQ-033 SHALL cover rst asserted at CALC cycle 3 -> next cycle in_ready=1, out_valid=0; a fresh operation then gives the correct result.
REQ-034 SHALL cover randomized K=64, D in {1,2,4,8}, odd m, x,y<m -> res equals the reference model x*y*2^-64 mod m for 10k vectors.
